// File: rtl/servo_pwm_if.sv
// Control/status bundle for servo_pwm_bank: period and per-channel pulse
// widths with a load strobe, plus the PWM outputs and status flags.
interface servo_pwm_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12
);
  logic                      en;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] pulsewidth;
  logic                      load;
  logic                      pending;
  logic                      period_done;
  logic [CHANNELS-1:0]       pwm_sig;

  modport master (
    output en, period, pulsewidth, load,
    input  pending, period_done, pwm_sig
  );

  modport slave (
    input  en, period, pulsewidth, load,
    output pending, period_done, pwm_sig
  );
endinterface

// File: rtl/servo_pwm_bank.sv
// Bank of PWM channels sharing one period counter, with double-buffered settings.
// Define SERVO_PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter.
module servo_pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12
) (
  input  logic           clk,
  input  logic           rst,
  servo_pwm_if.slave     bus
);
  typedef logic [WIDTH-1:0]          word_t;
  typedef logic [CHANNELS*WIDTH-1:0] lanes_t;

  word_t               shd_period, act_period, cnt;
  lanes_t              shd_pw, act_pw;
  logic                pending_q, done_q, en_q;
  logic [CHANNELS-1:0] pwm_q;

  logic                en_rise, have_new, use_new, take;
  logic                period_zero, boundary;
  word_t               src_period, eff_period, cnt_nxt;
  lanes_t              src_pw, eff_pw;
  logic [CHANNELS-1:0] pwm_nxt;

`ifdef SERVO_PWM_CENTER_ALIGN_EN
  logic down_q, down_nxt;
`endif

  // On the first enabled cycle the new settings must already drive the
  // compare, otherwise the restarted period would begin with stale values.
  assign en_rise     = bus.en & ~en_q;
  assign have_new    = bus.load | pending_q;
  assign use_new     = en_rise & have_new;
  assign src_period  = bus.load ? bus.period     : shd_period;
  assign src_pw      = bus.load ? bus.pulsewidth : shd_pw;
  assign eff_period  = use_new  ? src_period     : act_period;
  assign eff_pw      = use_new  ? src_pw         : act_pw;
  assign period_zero = (eff_period == '0);

`ifdef SERVO_PWM_CENTER_ALIGN_EN
  assign boundary = period_zero
                  | (down_q  && cnt == word_t'(1))
                  | (!down_q && cnt == eff_period && eff_period == word_t'(1));
`else
  assign boundary = period_zero | (cnt == eff_period - word_t'(1));
`endif

  assign take = bus.en & have_new & (boundary | en_rise);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_nxt = '0;
`ifdef SERVO_PWM_CENTER_ALIGN_EN
    down_nxt = 1'b0;
    if (bus.en && !boundary) begin
      if (!down_q && cnt == eff_period) begin
        cnt_nxt  = cnt - word_t'(1);
        down_nxt = 1'b1;
      end else if (down_q) begin
        cnt_nxt  = cnt - word_t'(1);
        down_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + word_t'(1);
      end
    end
`else
    if (bus.en && !boundary) cnt_nxt = cnt + word_t'(1);
`endif
  end

  always_comb begin
    pwm_nxt = '0;
    for (int i = 0; i < CHANNELS; i++)
      pwm_nxt[i] = bus.en && !period_zero && (cnt < eff_pw[i*WIDTH +: WIDTH]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the settings registers are reset too, so a released bank stays
      // silent (period 0) until software loads a real period.
      shd_period <= '0;
      shd_pw     <= '0;
      act_period <= '0;
      act_pw     <= '0;
      cnt        <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      pwm_q      <= '0;
`ifdef SERVO_PWM_CENTER_ALIGN_EN
      down_q     <= 1'b0;
`endif
    end else begin
      en_q   <= bus.en;
      cnt    <= cnt_nxt;
      pwm_q  <= pwm_nxt;
      done_q <= bus.en & boundary & ~period_zero;
`ifdef SERVO_PWM_CENTER_ALIGN_EN
      down_q <= down_nxt;
`endif
      if (bus.load) begin
        shd_period <= bus.period;
        shd_pw     <= bus.pulsewidth;
      end
      if (take) begin
        act_period <= src_period;
        act_pw     <= src_pw;
        pending_q  <= 1'b0;
      end else if (bus.load) begin
        pending_q  <= 1'b1;
      end
    end
  end

  assign bus.pending     = pending_q;
  assign bus.period_done = done_q;
  assign bus.pwm_sig     = pwm_q;
endmodule
